// File: rtl/if_pc_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register,
// applies hazard-unit stall/flush and turns pending interrupts into redirects.
module if_pc_stage #(
  parameter logic [31:0] RESET_PC   = 32'h80000000,
  parameter logic [31:0] ILLOP_ADDR = 32'h80000004,
  parameter logic [31:0] XADR_ADDR  = 32'h80000008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  PCSrcID,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JRTarget,
  input  logic        intterupt,
  input  logic [31:0] InstrMem,
  output logic [31:0] PC,
  output logic [31:0] InstructionID,
  output logic [31:0] PCplus4ID,
  output logic        ValidID,
  output logic        IntID
);

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_REDIRECT,
    ACT_INTERRUPT,
    ACT_ADVANCE
  } edgeAction_e;

  edgeAction_e action;
  logic        pending;
  logic        pendingNext;
  logic        intTake;
  logic [31:0] pcPlus4;
  logic [31:0] redirectPc;

  assign pcPlus4 = PC + 32'd4;

  always_comb begin
    redirectPc = pcPlus4;
    case (PCSrcID)
      3'd1:    redirectPc = BranchTarget;
      3'd2:    redirectPc = JumpTarget;
      3'd3:    redirectPc = JRTarget;
      3'd4:    redirectPc = ILLOP_ADDR;
      3'd5:    redirectPc = XADR_ADDR;
      default: redirectPc = pcPlus4;
    endcase
  end

  // Interrupts are masked in kernel mode and only taken on a plain sequential edge.
  assign intTake = pending && !PC[31] && (PCSrcID == 3'd0);

  always_comb begin
    action = ACT_ADVANCE;
    if (stall) begin
      action = ACT_HOLD;
    end else if (flush) begin
      action = ACT_REDIRECT;
    end else if (intTake) begin
      action = ACT_INTERRUPT;
    end
  end

  // Taking the interrupt wins over a simultaneous new request.
  assign pendingNext = (action == ACT_INTERRUPT) ? 1'b0 : (pending | intterupt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC            <= RESET_PC;
      InstructionID <= 32'd0;
      PCplus4ID     <= 32'd0;
      ValidID       <= 1'b0;
      IntID         <= 1'b0;
      pending       <= 1'b0;
    end else begin
      pending <= pendingNext;
      case (action)
        ACT_HOLD: begin
        end
        ACT_REDIRECT: begin
          PC            <= redirectPc;
          InstructionID <= 32'd0;
          PCplus4ID     <= 32'd0;
          ValidID       <= 1'b0;
          IntID         <= 1'b0;
        end
        ACT_INTERRUPT: begin
          // Resume address is the fetch address whose word is being dropped.
          PC            <= ILLOP_ADDR;
          InstructionID <= 32'd0;
          PCplus4ID     <= PC;
          ValidID       <= 1'b0;
          IntID         <= 1'b1;
        end
        ACT_ADVANCE: begin
          PC            <= pcPlus4;
          InstructionID <= InstrMem;
          PCplus4ID     <= pcPlus4;
          ValidID       <= 1'b1;
          IntID         <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_pc_stage.sv
// Scoreboard bench for if_pc_stage: directed scenarios plus random traffic
// checked against a per-edge behavioural model of the fetch stage.
module tb_if_pc_stage;

  localparam logic [31:0] RESET_PC   = 32'h80000000;
  localparam logic [31:0] ILLOP_ADDR = 32'h80000004;
  localparam logic [31:0] XADR_ADDR  = 32'h80000008;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        valid;
    logic        intr;
  } expT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  PCSrcID = 3'd0;
  logic [31:0] BranchTarget = 32'd0;
  logic [31:0] JumpTarget = 32'd0;
  logic [31:0] JRTarget = 32'd0;
  logic        intterupt = 1'b0;
  logic [31:0] InstrMem = 32'd0;
  logic [31:0] PC;
  logic [31:0] InstructionID;
  logic [31:0] PCplus4ID;
  logic        ValidID;
  logic        IntID;

  expT         expQ[$];
  int          checks = 0;
  int          failures = 0;

  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mP4;
  logic        mValid;
  logic        mInt;
  logic        mPend;

  if_pc_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .PCSrcID(PCSrcID),
    .BranchTarget(BranchTarget), .JumpTarget(JumpTarget), .JRTarget(JRTarget),
    .intterupt(intterupt), .InstrMem(InstrMem), .PC(PC),
    .InstructionID(InstructionID), .PCplus4ID(PCplus4ID),
    .ValidID(ValidID), .IntID(IntID)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPc = RESET_PC; mInstr = 32'd0; mP4 = 32'd0;
    mValid = 1'b0; mInt = 1'b0; mPend = 1'b0;
  endtask

  // One clock edge of stimulus; the model decides what IF should show after it.
  task automatic applyStimulus(input logic st, input logic fl, input logic [2:0] src,
                               input logic [31:0] bt, input logic [31:0] jt,
                               input logic [31:0] jrt, input logic intr,
                               input logic [31:0] instr);
    logic [31:0] target;
    @(negedge clk);
    stall = st; flush = fl; PCSrcID = src; BranchTarget = bt;
    JumpTarget = jt; JRTarget = jrt; intterupt = intr; InstrMem = instr;
    case (src)
      3'd1:    target = bt;
      3'd2:    target = jt;
      3'd3:    target = jrt;
      3'd4:    target = ILLOP_ADDR;
      3'd5:    target = XADR_ADDR;
      default: target = mPc + 32'd4;
    endcase
    if (st) begin
      mPend = mPend | intr;
    end else if (fl) begin
      mPc = target; mInstr = 32'd0; mP4 = 32'd0; mValid = 1'b0; mInt = 1'b0;
      mPend = mPend | intr;
    end else if (mPend && !mPc[31] && src == 3'd0) begin
      mP4 = mPc; mInstr = 32'd0; mValid = 1'b0; mInt = 1'b1;
      mPc = ILLOP_ADDR; mPend = 1'b0;
    end else begin
      mInstr = instr; mP4 = mPc + 32'd4; mValid = 1'b1; mInt = 1'b0;
      mPc = mPc + 32'd4; mPend = mPend | intr;
    end
    expQ.push_back('{pc: mPc, instr: mInstr, p4: mP4, valid: mValid, intr: mInt});
  endtask

  task automatic normalEdge(input logic [31:0] instr, input logic intr);
    applyStimulus(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, intr, instr);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".PC"}, PC, RESET_PC);
    checkOutput({tag, ".InstructionID"}, InstructionID, 32'd0);
    checkOutput({tag, ".PCplus4ID"}, PCplus4ID, 32'd0);
    checkOutput({tag, ".ValidID"}, {31'd0, ValidID}, 32'd0);
    checkOutput({tag, ".IntID"}, {31'd0, IntID}, 32'd0);
  endtask

  task automatic doAsyncReset(input string tag);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 checkResetOutputs(tag);
    modelReset();
    #1 reset = 1'b1;
  endtask

  // Monitor: every edge the driver produced an expectation for is compared here.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("PC", PC, e.pc);
        checkOutput("InstructionID", InstructionID, e.instr);
        checkOutput("PCplus4ID", PCplus4ID, e.p4);
        checkOutput("ValidID", {31'd0, ValidID}, {31'd0, e.valid});
        checkOutput("IntID", {31'd0, IntID}, {31'd0, e.intr});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic st, fl, intr;
    logic [2:0] src;
    modelReset();
    reset = 1'b0;
    #1 checkResetOutputs("initialReset");
    @(posedge clk);
    #2 reset = 1'b1;

    // Free-running kernel fetch
    repeat (3) normalEdge(32'h20080001, 1'b0);

    // Stall at a user-mode address
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h00400010, 32'd0, 32'd0, 1'b0, 32'h11111111);
    normalEdge(32'h22222222, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h00400010, 32'd0, 32'd0, 1'b0, 32'h33333333);
    applyStimulus(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'h44444444);
    applyStimulus(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'h55555555);
    normalEdge(32'h66666666, 1'b0);

    // Branch redirect, then an illegal stall+flush where stall must win
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h00400020, 32'd0, 32'd0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h00400100, 32'd0, 32'd0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 3'd2, 32'd0, 32'h00400300, 32'd0, 1'b0, 32'h0);

    // User-mode interrupt, request arriving on the redirect edge
    applyStimulus(1'b0, 1'b1, 3'd3, 32'd0, 32'd0, 32'h00400030, 1'b1, 32'h0);
    normalEdge(32'h77777777, 1'b0);
    normalEdge(32'h88888888, 1'b0);

    // Kernel mode masks a request until the PC returns to user space
    normalEdge(32'h99999999, 1'b1);
    normalEdge(32'hAAAAAAAA, 1'b0);
    applyStimulus(1'b0, 1'b1, 3'd3, 32'd0, 32'd0, 32'h00400040, 1'b0, 32'h0);
    normalEdge(32'hBBBBBBBB, 1'b0);

    // Interrupt on a jump-flush edge is deferred to the following edge
    applyStimulus(1'b0, 1'b1, 3'd2, 32'd0, 32'h00400200, 32'd0, 1'b1, 32'h0);
    normalEdge(32'hCCCCCCCC, 1'b0);

    // PC+4 wraps at the top of the address space
    applyStimulus(1'b0, 1'b1, 3'd3, 32'd0, 32'd0, 32'hFFFFFFFC, 1'b0, 32'h0);
    normalEdge(32'hDDDDDDDD, 1'b0);
    normalEdge(32'hEEEEEEEE, 1'b0);
    doAsyncReset("midReset");
    normalEdge(32'h20080001, 1'b0);

    for (int i = 0; i < 400; i++) begin
      st   = ($urandom_range(0, 99) < 15);
      fl   = ($urandom_range(0, 99) < 20);
      src  = ($urandom_range(0, 9) < 6) ? 3'd0 : 3'($urandom_range(1, 7));
      intr = ($urandom_range(0, 99) < 15);
      applyStimulus(st, fl, src, $urandom & 32'hFFFFFFFC, $urandom & 32'hFFFFFFFC,
                    $urandom & 32'hFFFFFFFC, intr, $urandom);
      if (i == 200) doAsyncReset("randomReset");
    end

    repeat (2) @(posedge clk);
    #2 checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
